arb_mux_nbit: RTL



---
 rtl/arb_mux_nbit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/arb_mux_nbit.sv
// Registered M-to-1 stream multiplexer with round-robin arbitration,
// valid/ready handshakes and an optional packet lock that holds the grant until in_last.
module arb_mux_nbit #(
  parameter int N    = 64,
  parameter int M    = 4,
  parameter int LOCK = 0,
  parameter int SW   = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [M-1:0]    in_valid,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_last,
  output logic [M-1:0]    in_ready,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic            out_last,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  localparam int unsigned MU = M;

  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;

  arb_state_e    state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [SW-1:0] lock_idx, lock_idx_nxt;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic [N-1:0]  grant_data;
  logic          grant_last;
  logic          space, accept;
  logic          out_valid_nxt, out_last_nxt;
  logic [N-1:0]  out_data_nxt;
  logic [SW-1:0] out_sel_nxt;
  int unsigned   best_off, off;

  // Each valid channel is ranked by its distance past ptr; the smallest distance wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    best_off    = MU;
    off         = 0;
    for (int unsigned j = 0; j < MU; j++) begin
      off = (j + MU - 1 - 32'(ptr)) % MU;
      if (in_valid[j] && (off < best_off)) begin
        best_off    = off;
        grant       = SW'(j);
        grant_valid = 1'b1;
      end
    end
    if (state == ARB_LOCKED) begin
      grant       = lock_idx;
      grant_valid = in_valid[lock_idx];
    end
  end

  always_comb begin
    grant_data = '0;
    grant_last = 1'b0;
    for (int unsigned j = 0; j < MU; j++) begin
      if (grant == SW'(j)) begin
        grant_data = in_data[j*N +: N];
        grant_last = in_last[j];
      end
    end
  end

  assign space  = !out_valid || out_ready;
  assign accept = reset_n && space && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int unsigned j = 0; j < MU; j++) begin
      in_ready[j] = accept && (grant == SW'(j));
    end
  end

  always_comb begin
    state_nxt     = state;
    lock_idx_nxt  = lock_idx;
    ptr_nxt       = ptr;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    out_sel_nxt   = out_sel;
    if (accept) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = grant_data;
      out_last_nxt  = grant_last;
      out_sel_nxt   = grant;
      ptr_nxt       = grant;
      if (LOCK != 0) begin
        lock_idx_nxt = grant;
        state_nxt    = grant_last ? ARB_FREE : ARB_LOCKED;
      end
    end else if (out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB_FREE;
      lock_idx  <= '0;
      ptr       <= SW'(M - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state     <= state_nxt;
      lock_idx  <= lock_idx_nxt;
      ptr       <= ptr_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      out_sel   <= out_sel_nxt;
    end
  end

endmodule
